mem_arbiter: RTL and testbench

Shares the single-ported `ram` between instruction fetch and load/store access, so the core can move from a dual-port idealised RAM to one memory port with variable latency. Sits between `if_stage` / `exe_stage` and the `ram` (or a future bus bridge); it accepts one request at a time, sequences it through a request/response handshake, and routes the response back to its owner. Load/store has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_starve_cnt.sv | 33 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and the latched-request record for the single-port memory arbiter.
// Imported by mem_arbiter and its starvation counter.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_WAIT = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int ARB_STARVE_MAX = 4;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } arb_txn_t;

  // Instruction words are 32 bits; addr[2] picks the half of the 64-bit beat.
  function automatic logic [31:0] sel_word(input logic hi, input logic [63:0] data);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of load/store grants taken while a fetch was waiting.
// limit tells the arbiter that fetch must win the next grant.
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam logic [2:0] LIMIT = 3'(MAX);

  logic [2:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign limit = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, one
// transaction at a time, with load/store priority bounded by a starvation limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  input  logic        if_kill,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_data,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,

  output logic        busy
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  arb_txn_t   r_txn;
  logic       r_killed;

  logic w_idle;
  logic w_limit;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_resp_fire;
  logic w_if_owned;
  logic w_starve_inc;
  logic w_starve_clr;

  assign w_idle      = (r_state == ARB_IDLE);
  // At the limit a waiting fetch overrides load/store; otherwise LS has priority.
  assign w_grant_ls  = w_idle & ls_req_valid & ~(w_limit & if_req_valid);
  assign w_grant_if  = w_idle & if_req_valid & ~w_grant_ls;
  assign w_resp_fire = (r_state == ARB_WAIT) & mem_resp_valid;
  assign w_if_owned  = ~w_idle & (r_txn.owner == OWN_IF);

  assign w_starve_inc = w_grant_ls & if_req_valid;
  assign w_starve_clr = w_grant_if | (w_idle & ~if_req_valid);

  arb_starve_cnt #(
    .MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_starve_inc),
    .clr  (w_starve_clr),
    .limit(w_limit)
  );

  // NOTE: the next-state default comes first so no path through the case
  // leaves w_state_nxt unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_if | w_grant_ls) w_state_nxt = ARB_REQ;
      ARB_REQ:  if (mem_req_ready)           w_state_nxt = ARB_WAIT;
      ARB_WAIT: if (mem_resp_valid)          w_state_nxt = ARB_IDLE;
      default:                               w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: the latched request fields are reset as well, so mem_* outputs read
  // zero after reset instead of whatever the previous transaction left behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_txn    <= '0;
      r_killed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant_ls) begin
        r_txn <= '{owner: OWN_LS, we: ls_we, addr: ls_addr, wdata: ls_wdata, wmask: ls_wmask};
      end else if (w_grant_if) begin
        r_txn <= '{owner: OWN_IF, we: 1'b0, addr: if_addr, wdata: '0, wmask: '0};
      end

      if (w_resp_fire) begin
        r_killed <= 1'b0;
      end else if (if_kill & (w_if_owned | w_grant_if)) begin
        r_killed <= 1'b1;
      end
    end
  end

  assign if_req_ready = w_grant_if;
  assign ls_req_ready = w_grant_ls;

  assign mem_req_valid = (r_state == ARB_REQ);
  assign mem_we        = r_txn.we;
  assign mem_addr      = r_txn.addr;
  assign mem_wdata     = r_txn.wdata;
  assign mem_wmask     = r_txn.wmask;

  // A kill arriving in the same cycle as the response still suppresses it.
  assign if_resp_valid = w_resp_fire & (r_txn.owner == OWN_IF) & ~r_killed & ~if_kill;
  assign if_resp_data  = sel_word(r_txn.addr[2], mem_resp_data);
  assign ls_resp_valid = w_resp_fire & (r_txn.owner == OWN_LS);
  assign ls_resp_data  = mem_resp_data;

  assign busy = ~w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_kill, if_resp_valid;
  logic [63:0] if_addr;
  logic [31:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_resp_data;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic [7:0]  mem_wmask;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_kill       (if_kill),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_we         (ls_we),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_data  (ls_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder controls.
  bit auto_mem  = 1'b0;
  bit rand_dly  = 1'b0;
  int ready_dly = 0;
  int resp_dly  = 0;

  // Transaction-level model of the arbiter.
  bit          m_out, m_hs, m_killed, m_owner_ls, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve;
  bit          acc_if, acc_ls;
  int          ls_grants;
  string       g_log, r_log;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h8000_0004) return 64'h1111_2222_3333_4444;
    return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
    end
  endtask

  // Compare one cycle of DUT outputs against the model, then advance the model.
  task automatic check_cycle();
    bit          was_idle, e_ls_rdy, e_if_rdy, e_mreq, done, e_if_resp, e_ls_resp;
    logic [63:0] d;
    acc_if = 1'b0;
    acc_ls = 1'b0;
    if (rst) begin
      m_out = 1'b0; m_hs = 1'b0; m_killed = 1'b0; m_starve = 0;
      return;
    end
    was_idle  = !m_out;
    e_ls_rdy  = was_idle && ls_req_valid && !(m_starve >= STARVE && if_req_valid);
    e_if_rdy  = was_idle && if_req_valid && !e_ls_rdy;
    e_mreq    = m_out && !m_hs;
    done      = m_out && m_hs && mem_resp_valid;
    e_ls_resp = done && m_owner_ls;
    e_if_resp = done && !m_owner_ls && !m_killed && !if_kill;
    d         = mem_fn(m_addr);

    chk("if_req_ready", if_req_ready, e_if_rdy);
    chk("ls_req_ready", ls_req_ready, e_ls_rdy);
    chk("busy", busy, m_out);
    chk("mem_req_valid", mem_req_valid, e_mreq);
    chk("if_resp_valid", if_resp_valid, e_if_resp);
    chk("ls_resp_valid", ls_resp_valid, e_ls_resp);
    if (e_mreq) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wmask", mem_wmask, m_wmask);
      if (m_owner_ls) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_ls_resp) chk("ls_resp_data", ls_resp_data, d);
    if (e_if_resp) chk("if_resp_data", if_resp_data, m_addr[2] ? d[63:32] : d[31:0]);

    if (if_req_valid && if_req_ready) g_log = {g_log, "I"};
    if (ls_req_valid && ls_req_ready) g_log = {g_log, "L"};
    if (if_resp_valid) r_log = {r_log, "I"};
    if (ls_resp_valid) r_log = {r_log, "L"};

    if (done) begin
      m_out = 1'b0; m_hs = 1'b0; m_killed = 1'b0;
    end else if (m_out) begin
      if (!m_hs && mem_req_ready) m_hs = 1'b1;
      if (if_kill && !m_owner_ls) m_killed = 1'b1;
    end
    if (was_idle) begin
      if (e_ls_rdy) begin
        m_out = 1'b1; m_hs = 1'b0; m_killed = 1'b0; m_owner_ls = 1'b1;
        m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
        m_starve = if_req_valid ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
        acc_ls = 1'b1;
        ls_grants++;
      end else if (e_if_rdy) begin
        m_out = 1'b1; m_hs = 1'b0; m_killed = if_kill; m_owner_ls = 1'b0;
        m_we = 1'b0; m_addr = if_addr; m_wmask = 8'h00;
        m_starve = 0;
        acc_if = 1'b1;
      end else if (!if_req_valid) begin
        m_starve = 0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit refill_if, input bit refill_ls);
    for (int i = 0; i < n; i++) begin
      at_neg();
      to_pos();
      if (acc_if) if_req_valid = refill_if;
      if (acc_ls) begin
        ls_req_valid = refill_ls;
        ls_addr      = ls_addr + 64'd8;
      end
    end
  endtask

  // Memory responder: ready after ready_dly extra REQ cycles, response resp_dly cycles later.
  initial begin
    int          phase, cnt, cur_rdy, cur_rsp;
    logic        seen_rst;
    logic [63:0] cap_addr;
    phase = 0; cnt = 0; cur_rdy = 0; cur_rsp = 0; cap_addr = '0;
    forever begin
      @(posedge clk);
      seen_rst = rst;
      #2;
      if (!auto_mem) begin
        phase = 0;
        continue;
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom(), $urandom()};
      if (seen_rst) begin
        phase = 0;
        continue;
      end
      if (phase == 0 && mem_req_valid) begin
        cur_rdy = rand_dly ? $urandom_range(0, 2) : ready_dly;
        cur_rsp = rand_dly ? $urandom_range(0, 3) : resp_dly;
        cnt     = cur_rdy;
        phase   = 1;
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          mem_req_ready = 1'b1;
          cap_addr      = mem_addr;
          cnt           = cur_rsp;
          phase         = 2;
        end else begin
          cnt--;
        end
      end else if (phase == 2) begin
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_fn(cap_addr);
          phase          = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt, pulses, guard;
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0; if_kill = 1'b0;
    ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    m_out = 1'b0; m_hs = 1'b0; m_killed = 1'b0; m_owner_ls = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_starve = 0; ls_grants = 0;
    g_log = ""; r_log = "";

    // Reset state.
    repeat (2) begin at_neg(); to_pos(); end
    rst = 1'b0;
    at_neg();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_if_req_ready", if_req_ready, 1'b0);
    chk("rst_ls_req_ready", ls_req_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_wmask", mem_wmask, 8'h00);
    to_pos();

    // IF-only fetch with zero-wait memory.
    auto_mem = 1'b1; ready_dly = 0; resp_dly = 0;
    if_addr = 64'h8000_0004; if_req_valid = 1'b1;
    at_neg();
    chk("if_only_ready", if_req_ready, 1'b1);
    to_pos();
    if_req_valid = 1'b0;
    at_neg();
    chk("if_only_mem_req", mem_req_valid, 1'b1);
    chk("if_only_mem_addr", mem_addr, 64'h8000_0004);
    to_pos();
    at_neg();
    chk("if_only_resp_valid", if_resp_valid, 1'b1);
    chk("if_only_resp_data", if_resp_data, 32'h1111_2222);
    chk("if_only_ls_resp", ls_resp_valid, 1'b0);
    to_pos();
    at_neg();
    chk("if_only_idle", busy, 1'b0);
    to_pos();

    // Simultaneous IF and LS load: LS first, then IF.
    g_log = ""; r_log = "";
    if_addr = 64'h0000_2000; if_req_valid = 1'b1;
    ls_we = 1'b0; ls_addr = 64'h0000_4000; ls_req_valid = 1'b1;
    run(8, 1'b0, 1'b0);
    chk_s("both_grant_order", g_log, "LI");
    chk_s("both_resp_order", r_log, "LI");

    // Starvation: both requesters continuously valid.
    g_log = ""; r_log = "";
    if_addr = 64'h0000_3000; if_req_valid = 1'b1;
    ls_addr = 64'h0000_5000; ls_req_valid = 1'b1;
    run(32, 1'b1, 1'b1);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    run(6, 1'b0, 1'b0);
    chk_s("starve_pattern", (g_log.len() >= 10) ? g_log.substr(0, 9) : g_log, "LLLLILLLLI");

    // Store with mem_req_ready delayed three cycles; request fields held through REQ.
    ready_dly = 3; resp_dly = 0;
    ls_we = 1'b1; ls_addr = 64'h0000_1000; ls_wdata = 64'hA5A5_0F0F_1234_5678; ls_wmask = 8'h0F;
    ls_req_valid = 1'b1;
    req_cnt = 0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (mem_req_valid && mem_we && mem_wmask == 8'h0F && mem_addr == 64'h1000) req_cnt++;
      if (ls_resp_valid) pulses++;
      to_pos();
      if (acc_ls) begin
        ls_req_valid = 1'b0; ls_addr = 64'hDEAD_0000; ls_wmask = 8'hFF; ls_we = 1'b0;
      end
    end
    chk("store_req_cycles", 64'(req_cnt), 64'd4);
    chk("store_ack_pulses", 64'(pulses), 64'd1);

    // Kill during IF WAIT, then a normal fetch.
    ready_dly = 0; resp_dly = 2;
    r_log = "";
    if_addr = 64'h0000_2000; if_req_valid = 1'b1;
    at_neg(); to_pos();
    if_req_valid = 1'b0;
    at_neg(); to_pos();
    if_kill = 1'b1;
    at_neg(); to_pos();
    if_kill = 1'b0;
    run(4, 1'b0, 1'b0);
    chk_s("kill_no_resp", r_log, "");
    at_neg();
    chk("kill_idle", busy, 1'b0);
    to_pos();
    resp_dly = 0;
    if_addr = 64'h0000_2004; if_req_valid = 1'b1;
    run(4, 1'b0, 1'b0);
    chk_s("after_kill_resp", r_log, "I");

    // Kill in the same cycle as the response.
    r_log = "";
    if_addr = 64'h0000_2008; if_req_valid = 1'b1;
    at_neg(); to_pos();
    if_req_valid = 1'b0;
    at_neg(); to_pos();
    if_kill = 1'b1;
    at_neg(); to_pos();
    if_kill = 1'b0;
    run(2, 1'b0, 1'b0);
    chk_s("kill_same_cycle", r_log, "");

    // Reset while waiting, starve count built up; late response afterwards.
    ready_dly = 0; resp_dly = 4; ls_grants = 0;
    if_addr = 64'h0000_5000; if_req_valid = 1'b1;
    ls_we = 1'b0; ls_addr = 64'h0000_6000; ls_req_valid = 1'b1;
    guard = 0;
    while (!(ls_grants >= 3 && m_hs) && guard < 40) begin
      at_neg(); to_pos();
      guard++;
    end
    chk("rst_test_reached_wait", 64'(ls_grants >= 3 && m_hs), 64'd1);
    rst = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    auto_mem = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    at_neg(); to_pos();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_EEEE_DDDD_CCCC;
    at_neg();
    chk("late_busy", busy, 1'b0);
    chk("late_ls_resp", ls_resp_valid, 1'b0);
    chk("late_if_resp", if_resp_valid, 1'b0);
    chk("late_mem_req_valid", mem_req_valid, 1'b0);
    chk("late_mem_addr", mem_addr, 64'h0);
    to_pos();
    mem_resp_valid = 1'b0; auto_mem = 1'b1; resp_dly = 0;
    g_log = "";
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    run(16, 1'b1, 1'b1);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    run(6, 1'b0, 1'b0);
    chk_s("post_rst_starve", (g_log.len() >= 5) ? g_log.substr(0, 4) : g_log, "LLLLI");

    // Randomized traffic with random memory latency and random kills.
    rand_dly = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      at_neg();
      to_pos();
      if (!if_req_valid || acc_if) begin
        if_req_valid = ($urandom_range(0, 2) != 0);
        if_addr      = {32'h0, $urandom() & 32'hFFFF_FFFC};
      end
      if (!ls_req_valid || acc_ls) begin
        ls_req_valid = ($urandom_range(0, 2) != 0);
        ls_we        = $urandom_range(0, 1) == 1;
        ls_addr      = {$urandom(), $urandom() & 32'hFFFF_FFF8};
        ls_wdata     = {$urandom(), $urandom()};
        ls_wmask     = 8'($urandom());
      end
      if_kill = ($urandom_range(0, 9) == 0);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0; if_kill = 1'b0;
    run(12, 1'b0, 1'b0);
    at_neg();
    chk("final_idle", busy, 1'b0);
    to_pos();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
